router_modport: RTL and testbench

// - 1x3 packet router core behind the team's router interface (SRC_DRV/SRC_MON/DST_DRV/DST_MON views).
// - Accepts byte-serial packets on one source port and steers each packet to one of three output FIFOs by header address.
// - Checks even (XOR) parity per packet and flags errors.
// - Each destination drains its FIFO through a vld_out/read_enb handshake.

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_fifo.sv | 87 ++++++++
 rtl/router_modport.sv | 211 +++++++++++++++++++++
 tb/tb_router_modport.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, constants and header helpers for the 1x3 packet router
package router_pkg;

    localparam int DATA_W_DEF = 8;

    // Address value that no destination answers to; such packets are dropped.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_DATA,
        FULL_WAIT,
        CHECK_PARITY,
        DROP
    } state_t;

    // Header byte layout: {len[5:0], addr[1:0]}
    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[1:0];
    endfunction

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[7:2];
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - one destination FIFO with flush and registered read data
//
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   flush         : synchronous empty (soft reset); wins over push/pop
//   push, push_data : write strobe and data; accepted when not full or when popping
//   pop           : read strobe; ignored while empty
//   pop_data      : registered read data, updated the cycle after a pop, held otherwise
//   full, empty   : occupancy flags
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              do_pop;
    logic              do_push;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = pop_data_q;

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pop_data_d = pop_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                pop_data_d = mem_q[rd_ptr_q];
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pop_data_q <= pop_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/router_modport.sv
// rtl/router_modport.sv - 1x3 byte-serial packet router with parity check and soft-reset FIFOs
//
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   data_in       : header / payload / parity byte from the source
//   pkt_valid     : high for header and payload, low on the parity byte
//   busy          : source must hold data_in/pkt_valid while high
//   err           : parity mismatch on the last completed packet
//   read_enb[2:0] : per-destination read strobe
//   vld_out[2:0]  : per-destination FIFO not empty
//   data_out[2:0] : per-destination registered read data
module router_modport
    import router_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int FIFO_DEPTH      = 16,
    parameter int SOFT_RST_CYCLES = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   pkt_valid,
    output logic                   busy,
    output logic                   err,
    input  logic [2:0]             read_enb,
    output logic [2:0]             vld_out,
    output logic [2:0][DATA_W-1:0] data_out
);

    localparam int CW = $clog2(SOFT_RST_CYCLES + 1);

    state_t            state_q, state_d;
    logic [1:0]        tgt_q, tgt_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic [DATA_W-1:0] rx_par_q, rx_par_d;
    logic              err_q, err_d;
    logic [CW-1:0]     soft_cnt_q [3];
    logic [CW-1:0]     soft_cnt_d [3];

    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] push;
    logic [2:0] soft_rst;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [1:0] hdr_a;

    assign hdr_a   = hdr_addr(data_in);
    assign vld_out = ~empty;
    assign err     = err_q;

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        par_d    = par_q;
        rx_par_d = rx_par_q;
        err_d    = err_q;
        busy     = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = tgt_q;

        case (state_q)
            IDLE: begin
                wr_sel = hdr_a;
                if (pkt_valid) begin
                    if (hdr_a == ADDR_INVALID) begin
                        state_d = DROP;
                    end else begin
                        tgt_d = hdr_a;
                        if (empty[hdr_a]) begin
                            wr_en   = 1'b1;
                            par_d   = data_in;
                            err_d   = 1'b0;
                            state_d = LOAD_DATA;
                        end else begin
                            // Header stays on the bus until the target drains.
                            busy    = 1'b1;
                            state_d = WAIT_EMPTY;
                        end
                    end
                end
            end

            WAIT_EMPTY: begin
                // busy falls in the cycle the held header is finally taken.
                if (empty[tgt_q]) begin
                    wr_en   = 1'b1;
                    par_d   = data_in;
                    err_d   = 1'b0;
                    state_d = LOAD_DATA;
                end else begin
                    busy = 1'b1;
                end
            end

            LOAD_DATA: begin
                if (soft_rst[tgt_q]) begin
                    state_d = IDLE;
                end else if (full[tgt_q]) begin
                    busy    = 1'b1;
                    state_d = FULL_WAIT;
                end else begin
                    wr_en = 1'b1;
                    if (pkt_valid) begin
                        par_d = par_q ^ data_in;
                    end else begin
                        rx_par_d = data_in;
                        state_d  = CHECK_PARITY;
                    end
                end
            end

            FULL_WAIT: begin
                if (soft_rst[tgt_q]) begin
                    state_d = IDLE;
                end else begin
                    busy = 1'b1;
                    if (!full[tgt_q]) begin
                        state_d = LOAD_DATA;
                    end
                end
            end

            CHECK_PARITY: begin
                busy    = 1'b1;
                err_d   = (par_q != rx_par_q);
                state_d = IDLE;
            end

            DROP: begin
                // The byte with pkt_valid low is the parity byte; it is discarded too.
                if (!pkt_valid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            push[i] = wr_en && (wr_sel == 2'(i));
        end
    end

    // ------------------------------------------------------------------
    // Soft-reset counters: count consecutive cycles with data waiting and
    // no read; a stuck destination is flushed after SOFT_RST_CYCLES.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            soft_rst[i] = (soft_cnt_q[i] == CW'(SOFT_RST_CYCLES));
            if (soft_rst[i]) begin
                soft_cnt_d[i] = '0;
            end else if (vld_out[i] && !read_enb[i]) begin
                soft_cnt_d[i] = soft_cnt_q[i] + CW'(1);
            end else begin
                soft_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            par_q    <= '0;
            rx_par_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                soft_cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            par_q    <= par_d;
            rx_par_q <= rx_par_d;
            err_q    <= err_d;
            for (int i = 0; i < 3; i++) begin
                soft_cnt_q[i] <= soft_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Destination FIFOs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_fifo
        router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (soft_rst[g]),
            .push      (push[g]),
            .push_data (data_in),
            .pop       (read_enb[g]),
            .pop_data  (data_out[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

endmodule

// File: tb/tb_router_modport.sv
// tb/tb_router_modport.sv - self-checking bench for router_modport
module tb_router_modport;

    logic            clock = 1'b0;
    logic            reset;
    logic [7:0]      data_in;
    logic            pkt_valid;
    logic            busy;
    logic            err;
    logic [2:0]      read_enb;
    logic [2:0]      vld_out;
    logic [2:0][7:0] data_out;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [3][$];
    logic [7:0] got_q [3][$];
    logic       exp_err = 1'b0;
    logic [2:0] pend = 3'b000;

    router_modport dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .err       (err),
        .read_enb  (read_enb),
        .vld_out   (vld_out),
        .data_out  (data_out)
    );

    always #5 clock = ~clock;

    // A pop sampled at posedge N shows on data_out after that edge; capture it
    // on the following negedge.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) got_q[i].push_back(data_out[i]);
        end
        pend = reset ? 3'b000 : (read_enb & vld_out);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one byte and hold it until the router is not busy; returns
    // just after the edge that accepted it.
    task automatic drive(input logic [7:0] d, input logic pv);
        int w = 0;
        data_in   = d;
        pkt_valid = pv;
        #1;
        while (busy === 1'b1 && w < 300) begin
            @(posedge clock);
            #2;
            w++;
        end
        if (w >= 300) check("busy_timeout", {31'b0, busy}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] calc_par(input logic [7:0] hdr, input logic [7:0] pl[$]);
        logic [7:0] p = hdr;
        foreach (pl[j]) p ^= pl[j];
        return p;
    endfunction

    // Reference model: a packet to a valid address appears verbatim (header,
    // payload, parity byte) at its destination; err reflects its parity.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$], input bit bad);
        logic [7:0] pb;
        pb = calc_par(hdr, pl) ^ (bad ? 8'h5A : 8'h00);
        drive(hdr, 1'b1);
        if (hdr[1:0] != 2'b11) check("hdr_err_clear", {31'b0, err}, 32'd0);
        foreach (pl[j]) drive(pl[j], 1'b1);
        drive(pb, 1'b0);
        data_in = 8'h00;
        if (hdr[1:0] != 2'b11) begin
            exp_q[hdr[1:0]].push_back(hdr);
            foreach (pl[j]) exp_q[hdr[1:0]].push_back(pl[j]);
            exp_q[hdr[1:0]].push_back(pb);
            exp_err = bad;
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        read_enb = 3'b111;
        while (vld_out !== 3'b000 && w < 200) begin
            tick();
            w++;
        end
        check($sformatf("%s_drain_empty", tag), {29'b0, vld_out}, 32'd0);
        tick();
        tick();
        read_enb = 3'b000;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_d%0d_count", tag, i), got_q[i].size(), exp_q[i].size());
            for (int j = 0; j < exp_q[i].size(); j++) begin
                check($sformatf("%s_d%0d_b%0d", tag, i, j),
                      (j < got_q[i].size()) ? {24'b0, got_q[i][j]} : 32'hDEAD_BEEF,
                      {24'b0, exp_q[i][j]});
            end
            got_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] pb;
        int         w;

        reset     = 1'b1;
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        read_enb  = 3'b000;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_vld", {29'b0, vld_out}, 32'd0);
        check("rst_data", {8'b0, data_out}, 32'd0);
        reset = 1'b0;
        tick();

        // Good packet to address 1
        pl = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h0D, pl, 1'b0);
        check("t1_vld", {29'b0, vld_out}, 32'h2);
        tick();
        check("t1_err", {31'b0, err}, {31'b0, exp_err});
        drain("t1");

        // Same packet with a corrupted parity byte
        send_pkt(8'h0D, pl, 1'b1);
        tick();
        check("t2_err", {31'b0, err}, {31'b0, exp_err});
        drain("t2");

        // Invalid address: dropped, err untouched
        pl = '{8'($urandom), 8'($urandom)};
        send_pkt(8'h0B, pl, 1'b0);
        tick();
        check("t3_vld", {29'b0, vld_out}, 32'd0);
        check("t3_err", {31'b0, err}, {31'b0, exp_err});
        drain("t3");

        // Next packet to address 2 routes normally and clears err
        pl = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send_pkt({6'd3, 2'd2}, pl, 1'b0);
        tick();
        check("t4_err", {31'b0, err}, {31'b0, exp_err});
        drain("t4");

        // 20-byte payload to address 0 with no reads: stalls at 16 entries
        pl.delete();
        for (int j = 0; j < 20; j++) pl.push_back(8'($urandom));
        pb = calc_par(8'h50, pl);
        drive(8'h50, 1'b1);
        for (int j = 0; j < 15; j++) drive(pl[j], 1'b1);
        data_in   = pl[15];
        pkt_valid = 1'b1;
        #1;
        check("t5_busy_full", {31'b0, busy}, 32'd1);
        check("t5_vld", {29'b0, vld_out}, 32'h1);
        read_enb = 3'b001;
        for (int j = 15; j < 20; j++) drive(pl[j], 1'b1);
        drive(pb, 1'b0);
        exp_q[0].push_back(8'h50);
        foreach (pl[j]) exp_q[0].push_back(pl[j]);
        exp_q[0].push_back(pb);
        exp_err = 1'b0;
        tick();
        check("t5_err", {31'b0, err}, {31'b0, exp_err});
        drain("t5");

        // Unread destination 2 is flushed SOFT_RST_CYCLES+1 edges after its header
        pl = '{8'($urandom), 8'($urandom)};
        send_pkt({6'd2, 2'd2}, pl, 1'b0);
        repeat (20) tick();
        check("t6_vld_hold", {31'b0, vld_out[2]}, 32'd1);
        w = 0;
        while (vld_out[2] === 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check("t6_flush", {31'b0, vld_out[2]}, 32'd0);
        check("t6_flush_cycle", w, 32'd8);
        exp_q[2].delete();
        drain("t6");

        // Async reset in the middle of a payload
        pl = '{8'($urandom)};
        send_pkt({6'd1, 2'd1}, pl, 1'b1);
        tick();
        check("t7_err_pre", {31'b0, err}, 32'd1);
        drive({6'd5, 2'd0}, 1'b1);
        drive(8'($urandom), 1'b1);
        drive(8'($urandom), 1'b1);
        #2;
        reset     = 1'b1;
        pkt_valid = 1'b0;
        #1;
        check("t7_busy", {31'b0, busy}, 32'd0);
        check("t7_err", {31'b0, err}, 32'd0);
        check("t7_vld", {29'b0, vld_out}, 32'd0);
        check("t7_data", {8'b0, data_out}, 32'd0);
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        exp_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        pl = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send_pkt({6'd4, 2'd0}, pl, 1'b0);
        tick();
        check("t7_after_err", {31'b0, err}, {31'b0, exp_err});
        drain("t7");

        // Random packets with reads running alongside
        for (int k = 0; k < 12; k++) begin
            logic [5:0] ln;
            logic [1:0] ad;
            bit         bad;
            ln  = 6'($urandom_range(1, 12));
            ad  = 2'($urandom_range(0, 3));
            bad = ($urandom_range(0, 3) == 0);
            pl.delete();
            for (int j = 0; j < int'(ln); j++) pl.push_back(8'($urandom));
            read_enb = 3'b111;
            send_pkt({ln, ad}, pl, bad);
            tick();
            check($sformatf("rnd%0d_err", k), {31'b0, err}, {31'b0, exp_err});
            drain($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
